// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I OP/OP-IMM decode, operand issue and writeback
// for a registered ALU that computes RS2 op RS1.
module alu_issue_stage #(
    parameter int WIDTH = 32,
    parameter int NREG  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,
    output logic [WIDTH:0]   alu_rs1,
    output logic [WIDTH:0]   alu_rs2,
    output logic [2:0]       alu_funct3,
    output logic             alu_funct7,
    output logic             alu_valid,
    input  logic [WIDTH:0]   alu_rd,
    output logic             illegal,
    input  logic [4:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);
    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;

    logic [WIDTH-1:0] r_regs [NREG];
    logic [WIDTH:0]   r_alu_rs1;
    logic [WIDTH:0]   r_alu_rs2;
    logic [2:0]       r_funct3;
    logic             r_funct7;
    logic             r_valid;
    logic             r_illegal;
    logic [4:0]       r_rd;
    logic             r_wb_pending;
    logic [4:0]       r_wb_rd;

    logic [6:0]       w_opc;
    logic [4:0]       w_rd;
    logic [2:0]       w_f3;
    logic [4:0]       w_rs1;
    logic [4:0]       w_rs2;
    logic             w_is_op;
    logic             w_is_imm;
    logic             w_legal;
    logic             w_shift;
    logic             w_fwd1;
    logic             w_fwd2;
    logic             w_stall;
    logic             w_accept;
    logic [WIDTH-1:0] w_rs1_val;
    logic [WIDTH-1:0] w_rs2_val;
    logic [WIDTH-1:0] w_opnd;
    logic             w_f7;
    logic             w_unused;

    assign w_opc    = instr[6:0];
    assign w_rd     = instr[11:7];
    assign w_f3     = instr[14:12];
    assign w_rs1    = instr[19:15];
    assign w_rs2    = instr[24:20];
    assign w_is_op  = (w_opc == OPC_OP);
    assign w_is_imm = (w_opc == OPC_IMM);
    assign w_legal  = w_is_op || w_is_imm;
    assign w_shift  = (w_f3 == 3'b001) || (w_f3 == 3'b101);
    assign w_unused = alu_rd[WIDTH];

    // Result of the instruction one ahead is on alu_rd until it commits.
    assign w_fwd1 = r_wb_pending && (r_wb_rd != 5'd0) && (r_wb_rd == w_rs1);
    assign w_fwd2 = r_wb_pending && (r_wb_rd != 5'd0) && (r_wb_rd == w_rs2);

    always_comb begin
        w_rs1_val = '0;
        if (w_rs1 != 5'd0) begin
            w_rs1_val = w_fwd1 ? alu_rd[WIDTH-1:0] : r_regs[w_rs1];
        end
    end

    always_comb begin
        w_rs2_val = '0;
        if (w_rs2 != 5'd0) begin
            w_rs2_val = w_fwd2 ? alu_rd[WIDTH-1:0] : r_regs[w_rs2];
        end
    end

    // The in-flight result is not yet on alu_rd, so wait one cycle.
    assign w_stall = r_valid && (r_rd != 5'd0) &&
                     ((w_legal && (w_rs1 == r_rd)) ||
                      (w_is_op && (w_rs2 == r_rd)));
    assign instr_ready = !w_stall;
    assign w_accept    = instr_valid && !w_stall;

    always_comb begin
        w_opnd = {{(WIDTH-12){instr[31]}}, instr[31:20]};
        w_f7   = 1'b0;
        unique case (1'b1)
            w_is_op: begin
                w_opnd = w_shift ? {{(WIDTH-5){1'b0}}, w_rs2_val[4:0]}
                                 : w_rs2_val;
                w_f7   = instr[30];
            end
            w_is_imm && w_shift: begin
                w_opnd = {{(WIDTH-5){1'b0}}, instr[24:20]};
                w_f7   = (w_f3 == 3'b101) && instr[30];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_rs1    <= '0;
            r_alu_rs2    <= '0;
            r_funct3     <= '0;
            r_funct7     <= 1'b0;
            r_valid      <= 1'b0;
            r_illegal    <= 1'b0;
            r_rd         <= '0;
            r_wb_pending <= 1'b0;
            r_wb_rd      <= '0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_valid   <= w_accept && w_legal;
            r_illegal <= w_accept && !w_legal;
            if (w_accept && w_legal) begin
                r_alu_rs1 <= {1'b0, w_opnd};
                r_alu_rs2 <= {1'b0, w_rs1_val};
                r_funct3  <= w_f3;
                r_funct7  <= w_f7;
                r_rd      <= w_rd;
            end
            r_wb_pending <= r_valid;
            r_wb_rd      <= r_rd;
            if (r_wb_pending && (r_wb_rd != 5'd0)) begin
                r_regs[r_wb_rd] <= alu_rd[WIDTH-1:0];
            end
        end
    end

    assign alu_rs1    = r_alu_rs1;
    assign alu_rs2    = r_alu_rs2;
    assign alu_funct3 = r_funct3;
    assign alu_funct7 = r_funct7;
    assign alu_valid  = r_valid;
    assign illegal    = r_illegal;
    assign dbg_data   = (dbg_addr == 5'd0) ? '0 : r_regs[dbg_addr];

endmodule
